e_mdu: RTL
==========

Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the E stage. It sits beside the single-cycle ALU, shares the same A/B operands from the forwarding muxes, and is the long-latency counterpart to that ALU.
- Owns the HI/LO architectural registers.
- Implements mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Reports Busy so the D-stage stall logic can hold later MDU instructions.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu.
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- MDUOp  input  4  operation select; encodings are listed under Decomposition.
- Start  input  1  one-cycle pulse; launches the mult/div named by MDUOp.
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- Busy  output  1  high while a mult/div is in flight.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- MDUOut  output  32  result for mfhi/mflo; otherwise 0.

Behaviour:
- Reset (synchronous, on a clk edge with reset=1):
  - HI, LO, the cycle counter, the pending HI/LO temporaries and Busy all clear to 0.
  - Any in-flight operation is abandoned; it does not commit.
  - reset has priority over Start and over mthi/mtlo.
- Launch:
  - A launch occurs on an edge where Start=1, Busy=0 and MDUOp is one of mult, multu, div, divu.
  - On that edge the unit computes the full result combinationally from A/B and latches it into tempHI/tempLO.
  - The counter loads MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
- Busy:
  - Busy = (counter != 0), registered.
  - Busy rises the cycle after Start and stays high for exactly N cycles.
  - The stall unit must treat (Start | Busy) as busy. The block itself ignores Start while Busy=1: the counter and temporaries are unchanged.
- Commit:
  - On the edge where the counter goes 1 -> 0, HI <= tempHI and LO <= tempLO.
  - The new HI/LO are visible in the same cycle that Busy first reads 0.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - multu: same split, unsigned.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Division by zero (B == 0): the counter still runs DIV_CYCLES, but HI/LO are not written at commit.
- mthi / mtlo:
  - When MDUOp = mthi (or mtlo) and Busy=0, HI (or LO) <= A on that edge; no Start is required.
  - Ignored while Busy=1.
- mfhi / mflo:
  - MDUOut is combinational: HI for mfhi, LO for mflo, 0 for every other op.
  - The read is of the current registers, so it does not observe an uncommitted result.
- Simultaneous events:
  - Start together with Busy: Start is ignored.
  - mthi/mtlo on the commit edge: cannot occur, because Busy=1 on that edge and the write is ignored.
  - Start on the cycle right after commit: accepted normally.
- Other MDUOp codes (0 and 9-15) are no-ops.

Decomposition:
- Shared package/header holds the MDUOp constants:
  - MDU_NONE = 0
  - MDU_MULT = 1
  - MDU_MULTU = 2
  - MDU_DIV = 3
  - MDU_DIVU = 4
  - MDU_MFHI = 5
  - MDU_MFLO = 6
  - MDU_MTHI = 7
  - MDU_MTLO = 8
- The D-stage decoder and the stall unit import the same constants.
- One natural sub-module, e_mdu_calc: purely combinational. It takes MDUOp, A and B and produces a 64-bit {hi, lo} result plus a div_by_zero flag. e_mdu keeps the counter, the temporaries and HI/LO.

Test Plan:
- mult, A=0xFFFFFFFF, B=0x00000002, Start pulse:
  - Busy high for 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - mfhi then gives MDUOut=0xFFFFFFFF.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div, A=0xFFFFFFF9 (-7), B=2:
  - Busy for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu with A=7, B=2 -> LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via mthi/mtlo, then div with B=0:
  - Busy for 10 cycles.
  - HI/LO remain 0x11/0x22.
- During a multu busy window:
  - A second Start with div and an mthi with A=0xABCD are both ignored.
  - Only the multu result commits, exactly 5 cycles after its Start.
- Start div, then assert reset on cycle 4:
  - Busy=0 and HI=LO=0 the next cycle.
  - No commit occurs later.
  - A new mult Start two cycles after reset completes normally.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: MDUOp encodings shared by the decoder, stall unit and the MDU.
package e_mdu_pkg;
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    function automatic logic is_mult(input logic [3:0] op);
        return op == MDU_MULT || op == MDU_MULTU;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op == MDU_DIV || op == MDU_DIVU;
    endfunction
endpackage

// File: rtl/e_mdu_calc.sv
// e_mdu_calc: combinational mult/div datapath producing {hi, lo} and a divide-by-zero flag.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_res,
    output logic        o_dz
);
    logic               w_bz;
    logic [31:0]        w_b;
    logic signed [63:0] w_ms;
    logic [63:0]        w_mu;
    logic signed [31:0] w_qs;
    logic signed [31:0] w_rs;
    logic [31:0]        w_qu;
    logic [31:0]        w_ru;

    assign w_bz = (i_b == '0);
    // Substitute a divisor of 1 so a zero divisor never reaches the dividers.
    assign w_b  = w_bz ? 32'd1 : i_b;
    assign w_ms = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_mu = {32'd0, i_a} * {32'd0, i_b};
    assign w_qs = $signed(i_a) / $signed(w_b);
    assign w_rs = $signed(i_a) % $signed(w_b);
    assign w_qu = i_a / w_b;
    assign w_ru = i_a % w_b;
    assign o_dz = w_bz && is_div(i_op);

    always_comb begin
        o_res = (i_op == MDU_MULT)  ? w_ms :
                (i_op == MDU_MULTU) ? w_mu :
                (i_op == MDU_DIV)   ? {w_rs, w_qs} :
                (i_op == MDU_DIVU)  ? {w_ru, w_qu} : 64'd0;
    end
endmodule

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning HI/LO; result commits when the busy counter expires.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_thi;
    logic [31:0]   r_tlo;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic          r_dz;
    logic [63:0]   w_res;
    logic          w_dz;
    logic          w_launch;

    e_mdu_calc u_calc (
        .i_op  (MDUOp),
        .i_a   (A),
        .i_b   (B),
        .o_res (w_res),
        .o_dz  (w_dz)
    );

    assign Busy     = (r_cnt != '0);
    assign w_launch = Start && !Busy && (is_mult(MDUOp) || is_div(MDUOp));
    assign HI       = r_hi;
    assign LO       = r_lo;

    always_comb begin
        MDUOut = (MDUOp == MDU_MFHI) ? r_hi :
                 (MDUOp == MDU_MFLO) ? r_lo : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_thi <= '0;
            r_tlo <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_dz  <= 1'b0;
        end else if (w_launch) begin
            r_cnt          <= is_mult(MDUOp) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            {r_thi, r_tlo} <= w_res;
            r_dz           <= w_dz;
        end else if (Busy) begin
            r_cnt <= r_cnt - CW'(1);
            // Divide-by-zero still burns the full latency but leaves HI/LO untouched.
            if (r_cnt == CW'(1) && !r_dz)
                {r_hi, r_lo} <= {r_thi, r_tlo};
        end else if (MDUOp == MDU_MTHI) begin
            r_hi <= A;
        end else if (MDUOp == MDU_MTLO) begin
            r_lo <= A;
        end
    end
endmodule
